// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler with valid/ready on both sides.
// Holds one full word in sr while the output register is still occupied.
module serial_word_deserializer #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         sin,
   input  logic         sin_valid,
   output logic         sin_ready,
   output logic [N-1:0] word,
   output logic         word_valid,
   input  logic         word_ready,
   output logic         busy
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      S_FILL,
      S_WAIT
   } state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  count;
   logic [N-1:0]   sr;
   logic           accept;
   logic           drain;
   logic           out_free;
   logic           last;
   logic           load_fill;
   logic           load_wait;

   assign accept    = sin_valid & sin_ready & ~clr;
   assign drain     = word_valid & word_ready;
   assign out_free  = ~word_valid | word_ready;
   assign last      = (count == LAST);
   assign load_fill = (state == S_FILL) & accept & last & out_free;
   assign load_wait = (state == S_WAIT) & drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FILL;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (clr) begin
         state_nx = S_FILL;
      end else begin
         unique case (state)
            S_FILL:
               if (accept & last & ~out_free) state_nx = S_WAIT;
            S_WAIT:
               if (drain) state_nx = S_FILL;
            default:
               state_nx = S_FILL;
         endcase
      end
   end

   always_comb begin
      sin_ready = (state == S_FILL);
      busy      = (count != '0) | (state == S_WAIT);
   end

   // sr and word survive clr; only the bookkeeping is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr         <= '0;
         count      <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else if (clr) begin
         count      <= '0;
         word_valid <= 1'b0;
      end else begin
         if (accept) begin
            sr    <= {sr[N-2:0], sin};
            count <= last ? '0 : count + CW'(1);
         end
         if (load_fill) begin
            word <= {sr[N-2:0], sin};
         end else if (load_wait) begin
            word <= sr;
         end
         if (load_fill | load_wait) begin
            word_valid <= 1'b1;
         end else if (drain) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (N=4 table, N=2 ordering).
// Each table row is driven at negedge and checked 1 time unit after posedge.
module tb_serial_word_deserializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       sin, sin_valid, word_ready;
   logic       sin_ready, word_valid, busy;
   logic [3:0] word;

   logic       sin2, sin_valid2, word_ready2;
   logic       sin_ready2, word_valid2, busy2;
   logic [1:0] word2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_word_deserializer #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready),
      .word(word), .word_valid(word_valid), .word_ready(word_ready),
      .busy(busy)
   );

   serial_word_deserializer #(.N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0),
      .sin(sin2), .sin_valid(sin_valid2), .sin_ready(sin_ready2),
      .word(word2), .word_valid(word_valid2), .word_ready(word_ready2),
      .busy(busy2)
   );

   typedef struct {
      logic       sv, s, wr, c;
      logic       rdy, wv;
      logic [3:0] w;
      logic       bz;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic sv, logic s, logic wr, logic c,
                               logic rdy, logic wv, logic [3:0] w,
                               logic bz);
      vec_t v;
      v.sv = sv; v.s = s; v.wr = wr; v.c = c;
      v.rdy = rdy; v.wv = wv; v.w = w; v.bz = bz;
      return v;
   endfunction

   task automatic drive(input logic sv, input logic s,
                        input logic wr, input logic c);
      @(negedge clk);
      sin_valid = sv; sin = s; word_ready = wr; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic async_rst(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, ".word"}, word, 0);
      chk({tag, ".wv"}, word_valid, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".rdy"}, sin_ready, 1);
      sin_valid = 0; word_ready = 0; clr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk({tag, ".rdy_rel"}, sin_ready, 1);
   endtask

   logic [11:0] t3bits;
   logic [3:0]  t3words [3];
   logic [1:0]  got2 [$];
   logic [1:0]  exp2 [2];
   logic [3:0]  bits2;

   initial begin
      rst_n = 0; clr = 0; sin = 0; sin_valid = 0; word_ready = 0;
      sin2 = 0; sin_valid2 = 0; word_ready2 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.word", word, 0);
      chk("reset.wv", word_valid, 0);
      chk("reset.busy", busy, 0);
      chk("reset.rdy", sin_ready, 1);
      @(negedge clk);
      rst_n = 1;

      // 1: single word 1011, valid for one cycle
      tv.push_back(mk(1, 1, 1, 0, 1, 0, 4'b0000, 1));
      tv.push_back(mk(1, 0, 1, 0, 1, 0, 4'b0000, 1));
      tv.push_back(mk(1, 1, 1, 0, 1, 0, 4'b0000, 1));
      tv.push_back(mk(1, 1, 1, 0, 1, 1, 4'b1011, 0));
      tv.push_back(mk(0, 1, 1, 0, 1, 0, 4'b1011, 0));
      // 2: backpressure into WAIT, then release
      tv.push_back(mk(1, 1, 0, 0, 1, 0, 4'b1011, 1));
      tv.push_back(mk(1, 1, 0, 0, 1, 0, 4'b1011, 1));
      tv.push_back(mk(1, 0, 0, 0, 1, 0, 4'b1011, 1));
      tv.push_back(mk(1, 0, 0, 0, 1, 1, 4'b1100, 0));
      tv.push_back(mk(1, 0, 0, 0, 1, 1, 4'b1100, 1));
      tv.push_back(mk(1, 1, 0, 0, 1, 1, 4'b1100, 1));
      tv.push_back(mk(1, 0, 0, 0, 1, 1, 4'b1100, 1));
      tv.push_back(mk(1, 1, 0, 0, 0, 1, 4'b1100, 1));
      tv.push_back(mk(1, 1, 0, 0, 0, 1, 4'b1100, 1));
      tv.push_back(mk(0, 0, 1, 0, 1, 1, 4'b0101, 0));
      tv.push_back(mk(0, 0, 1, 0, 1, 0, 4'b0101, 0));
      // 3: 12 bits back to back
      t3bits = 12'b1110_0011_0110;
      t3words[0] = 4'b1110;
      t3words[1] = 4'b0011;
      t3words[2] = 4'b0110;
      for (int k = 1; k <= 12; k++) begin
         logic [3:0] ew;
         ew = (k < 4) ? 4'b0101 : t3words[k/4 - 1];
         tv.push_back(mk(1, t3bits[12-k], 1, 0, 1, (k % 4) == 0, ew,
                         (k % 4) != 0));
      end
      tv.push_back(mk(0, 0, 1, 0, 1, 0, 4'b0110, 0));
      // 4: partial word then clr, then 1001; clr also kills a valid word
      tv.push_back(mk(1, 1, 1, 0, 1, 0, 4'b0110, 1));
      tv.push_back(mk(1, 1, 1, 0, 1, 0, 4'b0110, 1));
      tv.push_back(mk(1, 0, 1, 1, 1, 0, 4'b0110, 0));
      tv.push_back(mk(1, 1, 1, 0, 1, 0, 4'b0110, 1));
      tv.push_back(mk(1, 0, 1, 0, 1, 0, 4'b0110, 1));
      tv.push_back(mk(1, 0, 1, 0, 1, 0, 4'b0110, 1));
      tv.push_back(mk(1, 1, 1, 0, 1, 1, 4'b1001, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 4'b1001, 0));

      foreach (tv[i]) begin
         drive(tv[i].sv, tv[i].s, tv[i].wr, tv[i].c);
         chk($sformatf("vec%0d.rdy", i), sin_ready, tv[i].rdy);
         chk($sformatf("vec%0d.wv", i), word_valid, tv[i].wv);
         chk($sformatf("vec%0d.word", i), word, tv[i].w);
         chk($sformatf("vec%0d.busy", i), busy, tv[i].bz);
      end

      // 5a: async reset mid-word
      drive(1, 1, 0, 0);
      drive(1, 1, 0, 0);
      chk("t5a.busy_pre", busy, 1);
      async_rst("t5a");
      // 5b: async reset while in WAIT
      for (int k = 0; k < 8; k++) drive(1, k[0], 0, 0);
      chk("t5b.rdy_pre", sin_ready, 0);
      chk("t5b.wv_pre", word_valid, 1);
      async_rst("t5b");
      drive(1, 1, 1, 0);
      drive(1, 0, 1, 0);
      drive(1, 1, 1, 0);
      drive(1, 0, 1, 0);
      chk("t5c.word", word, 4'b1010);
      chk("t5c.wv", word_valid, 1);
      drive(0, 0, 0, 0);

      // 6: N=2, word_ready toggling every cycle
      bits2 = 4'b0110;
      exp2[0] = 2'b01;
      exp2[1] = 2'b10;
      begin
         int idx;
         idx = 0;
         for (int cyc = 0; cyc < 40; cyc++) begin
            logic acc;
            @(negedge clk);
            sin_valid2  = (idx < 4);
            sin2        = (idx < 4) ? bits2[3-idx] : 1'b0;
            word_ready2 = cyc[0];
            #1;
            acc = sin_valid2 & sin_ready2;
            if (word_valid2 & word_ready2) got2.push_back(word2);
            @(posedge clk);
            if (acc) idx++;
         end
         sin_valid2 = 0;
         chk("t6.bits_sent", idx, 4);
      end
      chk("t6.count", got2.size(), 2);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("t6.word%0d", i),
             (i < got2.size()) ? int'(got2[i]) : -1, exp2[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
